dino_jump_ctrl: RTL and testbench

Per-frame jump physics for the dino sprite. Turns a player jump button and a once-per-frame tick into the dino's height above ground. That height feeds the sprite layer's i_dino_vpos input, which positions the sprite vertically. Runs in the pixel clock domain and updates only on frame ticks, so the height never changes mid-frame.

---
 rtl/dino_pkg.sv | 29 ++
 rtl/button_sync_edge.sv | 39 +++
 rtl/dino_jump_ctrl.sv | 141 ++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the dino jump physics and the sprite layer.
//   HEIGHT_W    : width of the dino height bus (matches sprite i_dino_vpos)
//   VEL_W       : signed velocity register width
//   JUMP_VEL    : initial upward velocity, height units per frame
//   GRAVITY     : velocity decrement per frame tick
//   MAX_HEIGHT  : height clamp
//   dino_state_e: physics state (on ground, going up, coming down)
// -----------------------------------------------------------------------------
package dino_pkg;

  localparam int HEIGHT_W   = 4;
  localparam int VEL_W      = 6;
  localparam int JUMP_VEL   = 5;
  localparam int GRAVITY    = 1;
  localparam int MAX_HEIGHT = 15;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } dino_state_e;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// -----------------------------------------------------------------------------
// button_sync_edge
// Brings a raw asynchronous button level into the clk domain through a
// two-flop synchronizer and emits a one-cycle pulse on its rising edge.
//   clk    : destination clock
//   rst    : asynchronous active-high reset
//   i_btn  : raw button level, high = pressed
//   o_rise : one-cycle pulse when the synchronized level goes 0 -> 1
// -----------------------------------------------------------------------------
module button_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic sync1_q;
  logic sync2_q;
  logic level_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_d_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a true three-stage shift;
      // blocking ones would collapse the chain into a single flop.
      sync1_q   <= i_btn;
      sync2_q   <= sync1_q;
      level_d_q <= sync2_q;
    end
  end

  // A held button keeps sync2_q high, so only a fresh press after a release
  // produces another pulse.
  assign o_rise = sync2_q & ~level_d_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// -----------------------------------------------------------------------------
// dino_jump_ctrl
// Per-frame jump physics for the dino sprite. All motion happens on frame
// ticks, so the height output is stable for the whole visible frame.
//   clk          : pixel clock
//   rst          : asynchronous active-high reset
//   i_frame_tick : one-cycle pulse per frame (start of vblank)
//   i_jump_btn   : raw asynchronous jump button level
//   i_freeze     : game over / pause, holds all physics state
//   o_dino_vpos  : height above ground, 0 = on ground
//   o_airborne   : high while not running on the ground
//   o_jump_start : one-cycle pulse the cycle after a jump is accepted
//   o_land       : one-cycle pulse the cycle after landing
// -----------------------------------------------------------------------------
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int HEIGHT_W   = dino_pkg::HEIGHT_W,
  parameter int VEL_W      = dino_pkg::VEL_W,
  parameter int JUMP_VEL   = dino_pkg::JUMP_VEL,
  parameter int GRAVITY    = dino_pkg::GRAVITY,
  parameter int MAX_HEIGHT = dino_pkg::MAX_HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_frame_tick,
  input  logic                i_jump_btn,
  input  logic                i_freeze,
  output logic [HEIGHT_W-1:0] o_dino_vpos,
  output logic                o_airborne,
  output logic                o_jump_start,
  output logic                o_land
);

  localparam logic [HEIGHT_W-1:0]  JUMP_H_V = HEIGHT_W'(min_int(JUMP_VEL, MAX_HEIGHT));
  localparam logic [HEIGHT_W-1:0]  MAX_H_V  = HEIGHT_W'(MAX_HEIGHT);
  localparam logic signed [VEL_W:0]   MAX_H_S  = (VEL_W+1)'(MAX_HEIGHT);
  localparam logic signed [VEL_W:0]   ZERO_NH  = '0;
  localparam logic signed [VEL_W-1:0] ZERO_V   = '0;
  localparam logic signed [VEL_W-1:0] JUMP_V_S = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W-1:0] GRAV_S   = VEL_W'(GRAVITY);

  logic                      btn_rise;
  logic                      tick_en;
  dino_state_e               state_q, state_nxt;
  logic [HEIGHT_W-1:0]       height_q, height_nxt;
  logic signed [VEL_W-1:0]   vel_q, vel_nxt;
  logic signed [VEL_W-1:0]   vel_dec;
  logic signed [VEL_W:0]     next_h;
  logic                      pending_q, pending_nxt;
  logic                      jump_start_q, jump_acc;
  logic                      land_q, land_now;

  button_sync_edge u_jump_btn (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (i_jump_btn),
    .o_rise (btn_rise)
  );

  // State register (physics state, pending press, output pulses).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      height_q     <= '0;
      vel_q        <= '0;
      pending_q    <= 1'b0;
      jump_start_q <= 1'b0;
      land_q       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      height_q     <= height_nxt;
      vel_q        <= vel_nxt;
      pending_q    <= pending_nxt;
      jump_start_q <= jump_acc;
      land_q       <= land_now;
    end
  end

  // Next-state logic: everything moves only on an unfrozen frame tick.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path
    // leaves one unassigned, which would otherwise infer a latch.
    tick_en    = i_frame_tick & ~i_freeze;
    state_nxt  = state_q;
    height_nxt = height_q;
    vel_nxt    = vel_q;
    jump_acc   = 1'b0;
    land_now   = 1'b0;
    // Height is unsigned; widen both operands by one bit so a downward
    // velocity larger than the height shows up as a non-positive result.
    next_h  = $signed({{(VEL_W+1-HEIGHT_W){1'b0}}, height_q}) + $signed({vel_q[VEL_W-1], vel_q});
    vel_dec = vel_q - GRAV_S;

    if (tick_en) begin
      unique case (state_q)
        ST_RUN: begin
          // A press landing on the tick cycle itself counts as well.
          if (pending_q | btn_rise) begin
            height_nxt = JUMP_H_V;
            vel_nxt    = JUMP_V_S - GRAV_S;
            state_nxt  = ST_RISE;
            jump_acc   = 1'b1;
          end
        end
        ST_RISE, ST_FALL: begin
          if (next_h <= ZERO_NH) begin
            height_nxt = '0;
            vel_nxt    = '0;
            state_nxt  = ST_RUN;
            land_now   = 1'b1;
          end else begin
            height_nxt = (next_h > MAX_H_S) ? MAX_H_V : next_h[HEIGHT_W-1:0];
            vel_nxt    = vel_dec;
            state_nxt  = (vel_dec > ZERO_V) ? ST_RISE : ST_FALL;
          end
        end
        default: begin
          height_nxt = '0;
          vel_nxt    = '0;
          state_nxt  = ST_RUN;
        end
      endcase
    end

    // Every consumed tick drops a pending press, so presses made while
    // airborne are discarded rather than buffered for a double jump.
    if (tick_en || i_freeze) pending_nxt = 1'b0;
    else if (btn_rise)       pending_nxt = 1'b1;
    else                     pending_nxt = pending_q;
  end

  // Output logic: all outputs come straight from registers.
  always_comb begin
    o_dino_vpos  = height_q;
    o_airborne   = (state_q != ST_RUN);
    o_jump_start = jump_start_q;
    o_land       = land_q;
  end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dino_jump_ctrl
// Directed scenarios plus randomized button/freeze/tick traffic, compared
// every cycle against an integer-arithmetic model of the jump rules.
// -----------------------------------------------------------------------------
module tb_dino_jump_ctrl;
  import dino_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                tick;
  logic                btn;
  logic                freeze;
  logic [HEIGHT_W-1:0] vpos;
  logic                air;
  logic                js;
  logic                land;

  always #5 clk = ~clk;

  dino_jump_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_frame_tick (tick),
    .i_jump_btn   (btn),
    .i_freeze     (freeze),
    .o_dino_vpos  (vpos),
    .o_airborne   (air),
    .o_jump_start (js),
    .o_land       (land)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: height/velocity as integers, a flag for being off the
  // ground, and a history of button samples for the two-cycle sync delay.
  int m_h, m_v;
  bit m_air, m_pend, m_js, m_land;
  bit seen[$];

  task automatic model_reset();
    m_h = 0; m_v = 0; m_air = 0; m_pend = 0; m_js = 0; m_land = 0;
    seen.delete();
    repeat (3) seen.push_front(1'b0);
  endtask

  // Called once per rising clock edge with the inputs seen at that edge.
  task automatic model_step(input bit t, input bit b, input bit f);
    bit press;
    int nh;
    // Level synchronized two edges ago that was low one edge earlier.
    press  = seen[1] && !seen[2];
    m_js   = 0;
    m_land = 0;
    if (t && !f) begin
      if (!m_air) begin
        if (m_pend || press) begin
          m_h = (JUMP_VEL < MAX_HEIGHT) ? JUMP_VEL : MAX_HEIGHT;
          m_v = JUMP_VEL - GRAVITY;
          m_air = 1; m_js = 1;
        end
      end else begin
        nh = m_h + m_v;
        if (nh <= 0) begin
          m_h = 0; m_v = 0; m_air = 0; m_land = 1;
        end else begin
          m_h = (nh > MAX_HEIGHT) ? MAX_HEIGHT : nh;
          m_v = m_v - GRAVITY;
        end
      end
      m_pend = 0;
    end else if (f) begin
      m_pend = 0;
    end else if (press) begin
      m_pend = 1;
    end
    seen.push_front(b);
    if (seen.size() > 4) void'(seen.pop_back());
  endtask

  task automatic cycle(input bit t);
    tick = t;
    @(posedge clk);
    model_step(t, btn, freeze);
    #1;
    check("vpos", vpos, m_h);
    check("airborne", air, m_air);
    check("jump_start", js, m_js);
    check("land", land, m_land);
    check("pulse_overlap", js & land, 0);
  endtask

  task automatic frame(input int len = 8);
    repeat (len - 1) cycle(1'b0);
    cycle(1'b1);
  endtask

  int traj[11] = '{5, 9, 12, 14, 15, 15, 14, 12, 9, 5, 0};

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; btn = 1'b0; freeze = 1'b0;
    model_reset();
    #12;
    check("reset_vpos", vpos, 0);
    check("reset_air", air, 0);
    check("reset_js", js, 0);
    check("reset_land", land, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle: no button, stays on the ground.
    repeat (5) frame();
    check("idle_vpos", vpos, 0);

    // Single press before tick 1: full default trajectory.
    btn = 1'b1;
    frame();
    btn = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) frame();
      check("traj_h", vpos, traj[k]);
      check("traj_air", air, (k < 10) ? 1 : 0);
      check("traj_js", js, (k == 0) ? 1 : 0);
      check("traj_land", land, (k == 10) ? 1 : 0);
    end

    // Synchronized edge lands on the tick cycle itself.
    repeat (5) cycle(1'b0);
    btn = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    check("same_cycle_h", vpos, 5);
    check("same_cycle_js", js, 1);
    // Keep holding: land, then 30 more ticks without a retrigger.
    repeat (10) frame();
    check("held_landed", vpos, 0);
    repeat (30) frame();
    check("held_no_rejump_h", vpos, 0);
    check("held_no_rejump_air", air, 0);
    btn = 1'b0;
    frame();
    btn = 1'b1;
    frame();
    btn = 1'b0;
    check("repress_h", vpos, 5);

    // Press while airborne at height 12 is discarded.
    frame();
    frame();
    check("air_press_h12", vpos, 12);
    btn = 1'b1;
    repeat (3) cycle(1'b0);
    btn = 1'b0;
    repeat (4) cycle(1'b0);
    cycle(1'b1);
    check("air_press_h14", vpos, 14);
    repeat (7) frame();
    check("air_press_land", land, 1);
    check("air_press_ground", vpos, 0);
    repeat (5) frame();
    check("air_press_no_rejump", air, 0);

    // Freeze at height 14 for 10 ticks.
    btn = 1'b1;
    frame();
    btn = 1'b0;
    repeat (3) frame();
    check("pre_freeze_h", vpos, 14);
    freeze = 1'b1;
    repeat (10) frame();
    check("frozen_h", vpos, 14);
    check("frozen_air", air, 1);
    freeze = 1'b0;
    frame();
    check("resume_h1", vpos, 15);
    frame();
    check("resume_h2", vpos, 15);
    frame();
    check("resume_h3", vpos, 14);
    repeat (4) frame();
    check("resume_landed", vpos, 0);

    // Asynchronous reset mid-frame at height 9.
    btn = 1'b1;
    frame();
    btn = 1'b0;
    frame();
    check("pre_reset_h", vpos, 9);
    repeat (3) cycle(1'b0);
    #3 rst = 1'b1;
    #1;
    check("midreset_vpos", vpos, 0);
    check("midreset_air", air, 0);
    #2 rst = 1'b0;
    model_reset();
    btn = 1'b1;
    frame();
    btn = 1'b0;
    check("restart_h", vpos, 5);
    check("restart_js", js, 1);

    // Randomized traffic: button toggles, freezes, varying frame lengths.
    repeat (300) begin
      int len;
      len = $urandom_range(3, 10);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0)  btn = ~btn;
        if ($urandom_range(0, 39) == 0) freeze = ~freeze;
        cycle(i == len - 1);
      end
    end
    freeze = 1'b0;
    btn = 1'b0;
    repeat (20) frame();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
